// File: rtl/secded16_decoder_engine_pkg.sv
// Shared types and helpers for the SECDED(16,11) decoder engine.
// Codeword layout: e0 overall parity, e1/e2/e4/e8 Hamming parity, data elsewhere.
package secded16_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [4:0] FLAG_NONE   = 5'b00000;
  localparam logic [4:0] FLAG_SINGLE = 5'b01000;
  localparam logic [4:0] FLAG_DOUBLE = 5'b10000;

  // Codeword positions of d1..d11, in message bit order.
  localparam int DATA_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    logic [10:0] d;
    d = '0;
    for (int i = 0; i < 11; i++) begin
      d[i] = cw[DATA_POS[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/secded16_decoder_engine_if.sv
// Start/Ack request handshake plus the byte-wide data-memory port.
// master = decoder engine, slave = host/memory side.
interface secded16_decoder_engine_if #(
  parameter int ADDR_W = 8
);
  logic              Start;
  logic              Ack;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemWrEn;
  logic [7:0]        MemWrData;
  logic [7:0]        MemRdData;

  modport master (
    input  Start,
    input  MemRdData,
    output Ack,
    output MemAddr,
    output MemWrEn,
    output MemWrData
  );

  modport slave (
    output Start,
    output MemRdData,
    input  Ack,
    input  MemAddr,
    input  MemWrEn,
    input  MemWrData
  );
endinterface

// File: rtl/secded16_decoder_engine_decode.sv
// Combinational SECDED(16,11) decode: syndrome, single-bit correction, flags.
// Output is {flags[4:0], d11..d1}.
module secded16_decode_comb
  import secded16_pkg::*;
(
  input  logic [15:0] codeword,
  output logic [15:0] decoded
);

  logic [3:0]  syn;
  logic        glob;
  logic [15:0] corrected;
  logic [4:0]  flags;

  always_comb begin
    syn[0] = ^(codeword & 16'hAAAA);
    syn[1] = ^(codeword & 16'hCCCC);
    syn[2] = ^(codeword & 16'hF0F0);
    syn[3] = ^(codeword & 16'hFF00);
    glob   = ^codeword;

    corrected = codeword;
    flags     = FLAG_NONE;
    // Odd overall parity means one flipped bit; syndrome 0 points at p0 itself.
    if (glob) begin
      corrected[syn] = ~codeword[syn];
      flags          = FLAG_SINGLE;
    end else if (syn != 4'd0) begin
      flags = FLAG_DOUBLE;
    end

    decoded = {flags, extract_data(corrected)};
  end

endmodule

// File: rtl/secded16_decoder_engine.sv
// Walks NUM_WORDS encoded words at SRC_BASE, writes decoded words to DST_BASE,
// raises Ack when the whole block is done. Four clocks per word.
//
//   state | meaning
//   IDLE  | waiting for Start
//   RD_LO | reading low codeword byte
//   RD_HI | reading high codeword byte
//   WR_LO | writing low decoded byte
//   WR_HI | writing high decoded byte, then next word or DONE
//   DONE  | Ack held high; Start restarts
module secded16_decoder_engine
  import secded16_pkg::*;
#(
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15,
  parameter int ADDR_W    = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  secded16_decoder_engine_if.master   bus
);

  localparam int K_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [K_W-1:0]    K_LAST = K_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] SRC_A  = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A  = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [K_W-1:0]    k, k_nxt;
  logic [7:0]        lo, hi;
  logic [15:0]       decoded;
  logic [ADDR_W-1:0] two_k;

  assign two_k = ADDR_W'({k, 1'b0});

  secded16_decode_comb u_decode (
    .codeword ({hi, lo}),
    .decoded  (decoded)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      k     <= '0;
      lo    <= '0;
      hi    <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (state == RD_LO) lo <= bus.MemRdData;
      if (state == RD_HI) hi <= bus.MemRdData;
    end
  end

  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    bus.Ack       = 1'b0;
    bus.MemAddr   = '0;
    bus.MemWrEn   = 1'b0;
    bus.MemWrData = '0;

    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_nxt = RD_LO;
          k_nxt     = '0;
        end
      end
      RD_LO: begin
        bus.MemAddr = SRC_A + two_k;
        state_nxt   = RD_HI;
      end
      RD_HI: begin
        bus.MemAddr = SRC_A + two_k + ONE_A;
        state_nxt   = WR_LO;
      end
      WR_LO: begin
        bus.MemAddr   = DST_A + two_k;
        bus.MemWrEn   = 1'b1;
        bus.MemWrData = decoded[7:0];
        state_nxt     = WR_HI;
      end
      WR_HI: begin
        bus.MemAddr   = DST_A + two_k + ONE_A;
        bus.MemWrEn   = 1'b1;
        bus.MemWrData = decoded[15:8];
        if (k == K_LAST) begin
          state_nxt = DONE;
        end else begin
          k_nxt     = k + 1'b1;
          state_nxt = RD_LO;
        end
      end
      DONE: begin
        bus.Ack = 1'b1;
        if (bus.Start) begin
          state_nxt = RD_LO;
          k_nxt     = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
